// File: rtl/thread_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : thread_issue_sched
// Purpose  : 4-thread round-robin issue scheduler feeding a D->E1->E2->E3->WB
//            tag pipeline, with per-thread RUN/MWAIT/HALT state.
// Options  : SCHED_MEMWAIT_EN enables the memory-wait (MWAIT) state.
// Revision : 1.0
// ============================================================================
module thread_issue_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] rdy,
  input  logic       mem_op,
  input  logic [3:0] mem_done,
  input  logic [3:0] halt_req,
  input  logic [3:0] resume,
  output logic       issue_vld,
  output logic [1:0] issue_tid,
  output logic       e1_vld,
  output logic [1:0] e1_tid,
  output logic       e2_vld,
  output logic [1:0] e2_tid,
  output logic       e3_vld,
  output logic [1:0] e3_tid,
  output logic       wb_vld,
  output logic [1:0] wb_tid,
  output logic [3:0] stall,
  output logic [3:0] thr_halted,
  output logic [3:0] thr_mwait
);

  localparam int NTHR = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_HALT  = 2'd2
  } thr_state_t;

  logic [3:0] w_elig;
  logic       w_found;
  logic [1:0] w_win;
  logic [3:0] w_issue_oh;
  logic [1:0] r_ptr;

  logic       r_e1_vld, r_e2_vld, r_e3_vld, r_wb_vld;
  logic [1:0] r_e1_tid, r_e2_tid, r_e3_tid, r_wb_tid;

  // Per-thread state machines
  generate
    for (genvar t = 0; t < NTHR; t++) begin : g_thr
      thr_state_t r_state;
      thr_state_t w_next;

      always_comb begin
        w_next = r_state;
        if (halt_req[t]) begin
          w_next = ST_HALT;
        end else begin
          case (r_state)
            ST_HALT: if (resume[t]) w_next = ST_RUN;
`ifdef SCHED_MEMWAIT_EN
            ST_MWAIT: if (mem_done[t]) w_next = ST_RUN;
            ST_RUN: if (issue_vld && (issue_tid == 2'(t)) && mem_op) w_next = ST_MWAIT;
`endif
            default: w_next = r_state;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_next;
      end

      assign w_elig[t]     = rdy[t] & (r_state == ST_RUN);
      assign thr_halted[t] = (r_state == ST_HALT);
`ifdef SCHED_MEMWAIT_EN
      assign thr_mwait[t]  = (r_state == ST_MWAIT);
`else
      assign thr_mwait[t]  = 1'b0;
`endif
    end
  endgenerate

`ifndef SCHED_MEMWAIT_EN
  logic w_unused;
  assign w_unused = mem_op ^ (^mem_done);
`endif

  // Round-robin search starting just after the last issued thread
  always_comb begin
    logic [1:0] w_cand;
    w_found = 1'b0;
    w_win   = 2'd0;
    w_cand  = 2'd0;
    for (int k = 1; k <= NTHR; k++) begin
      w_cand = r_ptr + 2'(k);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Issue is suppressed while reset is held so outputs stay at reset values
  assign issue_vld  = en & ~rst & w_found;
  assign issue_tid  = issue_vld ? w_win : 2'd0;
  assign w_issue_oh = issue_vld ? (4'b0001 << issue_tid) : 4'b0000;
  assign stall      = rdy & ~w_issue_oh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= 2'd3;
      r_e1_vld <= 1'b0;
      r_e1_tid <= 2'd0;
      r_e2_vld <= 1'b0;
      r_e2_tid <= 2'd0;
      r_e3_vld <= 1'b0;
      r_e3_tid <= 2'd0;
      r_wb_vld <= 1'b0;
      r_wb_tid <= 2'd0;
    end else if (en) begin
      r_e1_vld <= issue_vld;
      r_e1_tid <= issue_tid;
      r_e2_vld <= r_e1_vld;
      r_e2_tid <= r_e1_tid;
      r_e3_vld <= r_e2_vld;
      r_e3_tid <= r_e2_tid;
      r_wb_vld <= r_e3_vld;
      r_wb_tid <= r_e3_tid;
      if (issue_vld) r_ptr <= issue_tid;
    end
  end

  assign e1_vld = r_e1_vld;
  assign e1_tid = r_e1_tid;
  assign e2_vld = r_e2_vld;
  assign e2_tid = r_e2_tid;
  assign e3_vld = r_e3_vld;
  assign e3_tid = r_e3_tid;
  assign wb_vld = r_wb_vld;
  assign wb_tid = r_wb_tid;

endmodule
`default_nettype wire

// File: tb/tb_thread_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_thread_issue_sched
// Purpose  : Self-checking bench for thread_issue_sched (directed + random).
// Revision : 1.0
// ============================================================================
module tb_thread_issue_sched;

  logic       clk = 1'b0;
  logic       rst, en, mem_op;
  logic [3:0] rdy, mem_done, halt_req, resume;
  logic       issue_vld, e1_vld, e2_vld, e3_vld, wb_vld;
  logic [1:0] issue_tid, e1_tid, e2_tid, e3_tid, wb_tid;
  logic [3:0] stall, thr_halted, thr_mwait;

  int chk = 0;
  int err = 0;

`ifdef SCHED_MEMWAIT_EN
  localparam bit MW = 1'b1;
`else
  localparam bit MW = 1'b0;
`endif

  always #5 clk = ~clk;

  thread_issue_sched dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .mem_op(mem_op),
    .mem_done(mem_done), .halt_req(halt_req), .resume(resume),
    .issue_vld(issue_vld), .issue_tid(issue_tid),
    .e1_vld(e1_vld), .e1_tid(e1_tid), .e2_vld(e2_vld), .e2_tid(e2_tid),
    .e3_vld(e3_vld), .e3_tid(e3_tid), .wb_vld(wb_vld), .wb_tid(wb_tid),
    .stall(stall), .thr_halted(thr_halted), .thr_mwait(thr_mwait)
  );

  // Reference model: thread states (0=run,1=mwait,2=halt), last winner, and
  // a queue of in-flight TIDs (-1 = bubble), index 0 = E1 ... 3 = WB.
  int         m_state[4];
  int         m_ptr;
  int         m_pipe[$];
  bit         x_vld;
  logic [1:0] x_tid;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_state[i] = 0;
    m_ptr  = 3;
    m_pipe = '{-1, -1, -1, -1};
  endfunction

  function automatic void model_issue();
    x_vld = 1'b0;
    x_tid = 2'd0;
    if (en && !rst) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (!x_vld && rdy[c] && m_state[c] == 0) begin
          x_vld = 1'b1;
          x_tid = c[1:0];
        end
      end
    end
  endfunction

  function automatic logic [3:0] exp_stall();
    logic [3:0] s;
    for (int t = 0; t < 4; t++) s[t] = rdy[t] && !(x_vld && x_tid == t[1:0]);
    return s;
  endfunction

  function automatic logic [3:0] exp_state_flags(input int st);
    logic [3:0] f;
    for (int t = 0; t < 4; t++) f[t] = (m_state[t] == st);
    return f;
  endfunction

  function automatic logic [11:0] exp_tags();
    logic [11:0] v;
    v = '0;
    for (int s = 0; s < 4; s++) begin
      int p;
      p = m_pipe[s];
      if (p >= 0) v[11-3*s -: 3] = {1'b1, p[1:0]};
    end
    return v;
  endfunction

  function automatic logic [11:0] dut_tags();
    return {e1_vld, e1_tid, e2_vld, e2_tid, e3_vld, e3_tid, wb_vld, wb_tid};
  endfunction

  // Advance one clock: model follows the same edge, returns at the negedge.
  task automatic tick();
    int ns[4];
    model_issue();
    @(posedge clk);
    for (int t = 0; t < 4; t++) begin
      if (halt_req[t])            ns[t] = 2;
      else if (m_state[t] == 2)   ns[t] = resume[t] ? 0 : 2;
      else if (m_state[t] == 1)   ns[t] = mem_done[t] ? 0 : 1;
      else ns[t] = (MW && x_vld && x_tid == t[1:0] && mem_op) ? 1 : 0;
    end
    for (int t = 0; t < 4; t++) m_state[t] = ns[t];
    if (en) begin
      m_pipe.push_front(x_vld ? int'(x_tid) : -1);
      void'(m_pipe.pop_back());
      if (x_vld) m_ptr = int'(x_tid);
    end
    @(negedge clk);
  endtask

  task automatic clr_pulses();
    mem_done = 4'h0;
    halt_req = 4'h0;
    resume   = 4'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; rdy = 4'hF; mem_op = 1'b0;
    clr_pulses();
    model_reset();
    @(negedge clk); #1;
    chk++; if (issue_vld !== 1'b0) begin err++; $display("FAIL reset_issue_vld: got %b want 0", issue_vld); end
    chk++; if (dut_tags() !== 12'h000) begin err++; $display("FAIL reset_tags: got %h want 000", dut_tags()); end
    chk++; if ({thr_halted, thr_mwait} !== 8'h00) begin err++; $display("FAIL reset_flags: got %h want 00", {thr_halted, thr_mwait}); end
    @(posedge clk); #1;
    chk++; if ({issue_vld, issue_tid} !== 3'b000) begin err++; $display("FAIL reset_hold_issue: got %b want 000", {issue_vld, issue_tid}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    en = 1'b1; rdy = 4'hF; mem_op = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk++; if ({issue_vld, issue_tid} !== {1'b1, 2'(i % 4)}) begin
        err++; $display("FAIL rr_issue[%0d]: got %b want %b", i, {issue_vld, issue_tid}, {1'b1, 2'(i % 4)}); end
      if (i >= 4) begin
        chk++; if ({wb_vld, wb_tid} !== {1'b1, 2'((i - 4) % 4)}) begin
          err++; $display("FAIL rr_wb[%0d]: got %b want %b", i, {wb_vld, wb_tid}, {1'b1, 2'((i - 4) % 4)}); end
      end else begin
        chk++; if (wb_vld !== 1'b0) begin err++; $display("FAIL rr_wb_empty[%0d]: got %b want 0", i, wb_vld); end
      end
      tick();
    end
  endtask

  task automatic test_alternate();
    logic [1:0] want_tid;
    logic [3:0] want_stall;
    do_reset();
    en = 1'b1; rdy = 4'b0101; mem_op = 1'b0;
    for (int i = 0; i < 6; i++) begin
      want_tid   = (i % 2 == 1) ? 2'd2 : 2'd0;
      want_stall = (i % 2 == 1) ? 4'b0001 : 4'b0100;
      #1;
      chk++; if ({issue_vld, issue_tid} !== {1'b1, want_tid}) begin
        err++; $display("FAIL alt_issue[%0d]: got %b want %b", i, {issue_vld, issue_tid}, {1'b1, want_tid}); end
      chk++; if (stall !== want_stall) begin
        err++; $display("FAIL alt_stall[%0d]: got %b want %b", i, stall, want_stall); end
      tick();
    end
  endtask

  task automatic test_memwait();
    do_reset();
    en = 1'b1; rdy = 4'hF; mem_op = 1'b0;
    tick();
    mem_op = 1'b1; #1;
    chk++; if ({issue_vld, issue_tid} !== 3'b101) begin err++; $display("FAIL mw_issue1: got %b want 101", {issue_vld, issue_tid}); end
    tick();
    mem_op = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; model_issue();
      chk++; if (thr_mwait !== (MW ? 4'b0010 : 4'b0000)) begin
        err++; $display("FAIL mw_flag[%0d]: got %b want %b", i, thr_mwait, (MW ? 4'b0010 : 4'b0000)); end
      chk++; if ({issue_vld, issue_tid} !== {x_vld, x_tid}) begin
        err++; $display("FAIL mw_skip[%0d]: got %b want %b", i, {issue_vld, issue_tid}, {x_vld, x_tid}); end
      tick();
    end
    rdy = 4'b0010; mem_done = 4'b0010; #1;
    chk++; if (issue_vld !== !MW) begin err++; $display("FAIL mw_blocked: got %b want %b", issue_vld, !MW); end
    tick();
    mem_done = 4'h0; #1;
    chk++; if (thr_mwait !== 4'b0000) begin err++; $display("FAIL mw_clear: got %b want 0000", thr_mwait); end
    chk++; if ({issue_vld, issue_tid} !== 3'b101) begin err++; $display("FAIL mw_reissue: got %b want 101", {issue_vld, issue_tid}); end
    tick();
  endtask

  task automatic test_halt_resume();
    logic [1:0] want;
    do_reset();
    en = 1'b1; rdy = 4'hF; mem_op = 1'b0;
    tick();
    tick();
    halt_req = 4'b0100; resume = 4'b0100; #1;
    chk++; if ({issue_vld, issue_tid} !== 3'b110) begin err++; $display("FAIL hr_issue2: got %b want 110", {issue_vld, issue_tid}); end
    tick();
    clr_pulses(); #1;
    chk++; if (thr_halted !== 4'b0100) begin err++; $display("FAIL hr_halted: got %b want 0100", thr_halted); end
    chk++; if ({e1_vld, e1_tid} !== 3'b110) begin err++; $display("FAIL hr_e1: got %b want 110", {e1_vld, e1_tid}); end
    for (int i = 0; i < 3; i++) begin
      want = (i == 0) ? 2'd3 : ((i == 1) ? 2'd0 : 2'd1);
      if (i > 0) #1;
      chk++; if ({issue_vld, issue_tid} !== {1'b1, want}) begin
        err++; $display("FAIL hr_skip[%0d]: got %b want %b", i, {issue_vld, issue_tid}, {1'b1, want}); end
      tick();
    end
    resume = 4'b0100; #1;
    chk++; if ({wb_vld, wb_tid} !== 3'b110) begin err++; $display("FAIL hr_drain_wb: got %b want 110", {wb_vld, wb_tid}); end
    tick();
    clr_pulses(); #1;
    chk++; if (thr_halted !== 4'b0000) begin err++; $display("FAIL hr_resumed: got %b want 0000", thr_halted); end
    tick();
  endtask

  task automatic test_enable_freeze();
    do_reset();
    en = 1'b1; rdy = 4'hF; mem_op = 1'b1;
    tick();
    mem_op = 1'b0;
    tick(); tick(); tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_done = (i == 1) ? 4'b0001 : 4'b0000; #1;
      chk++; if (issue_vld !== 1'b0) begin err++; $display("FAIL fz_issue[%0d]: got %b want 0", i, issue_vld); end
      chk++; if (dut_tags() !== 12'hFAC) begin err++; $display("FAIL fz_tags[%0d]: got %h want fac", i, dut_tags()); end
      if (i == 0) begin
        chk++; if (thr_mwait !== (MW ? 4'b0001 : 4'b0000)) begin
          err++; $display("FAIL fz_mwait_set: got %b want %b", thr_mwait, (MW ? 4'b0001 : 4'b0000)); end
      end
      if (i == 2) begin
        chk++; if (thr_mwait !== 4'b0000) begin err++; $display("FAIL fz_mwait_clr: got %b want 0000", thr_mwait); end
      end
      tick();
    end
    clr_pulses();
    en = 1'b1; #1;
    chk++; if ({issue_vld, issue_tid} !== 3'b100) begin err++; $display("FAIL fz_resume_ptr: got %b want 100", {issue_vld, issue_tid}); end
    tick();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    en = 1'b1; rdy = 4'hF; mem_op = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    halt_req = 4'b0010;
    tick();
    clr_pulses(); #1;
    chk++; if ({e1_vld, e2_vld, e3_vld, wb_vld} !== 4'hF) begin
      err++; $display("FAIL rm_full: got %b want 1111", {e1_vld, e2_vld, e3_vld, wb_vld}); end
    chk++; if (thr_halted !== 4'b0010) begin err++; $display("FAIL rm_halt_set: got %b want 0010", thr_halted); end
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk++; if (dut_tags() !== 12'h000) begin err++; $display("FAIL rm_async_tags: got %h want 000", dut_tags()); end
    chk++; if ({issue_vld, thr_halted} !== 5'b0) begin err++; $display("FAIL rm_async_state: got %b want 00000", {issue_vld, thr_halted}); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; #1;
    chk++; if ({issue_vld, issue_tid} !== 3'b100) begin err++; $display("FAIL rm_first_issue: got %b want 100", {issue_vld, issue_tid}); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom % 8) != 0;
      rdy      = 4'($urandom);
      mem_op   = 1'($urandom);
      mem_done = 4'($urandom) & 4'($urandom);
      halt_req = (($urandom % 10) == 0) ? (4'b0001 << ($urandom % 4)) : 4'h0;
      resume   = (($urandom % 3) == 0) ? 4'($urandom) : 4'h0;
      #1;
      model_issue();
      chk++; if ({issue_vld, issue_tid} !== {x_vld, x_tid}) begin
        err++; $display("FAIL rnd_issue[%0d]: got %b want %b", i, {issue_vld, issue_tid}, {x_vld, x_tid}); end
      chk++; if (stall !== exp_stall()) begin
        err++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall, exp_stall()); end
      chk++; if ({thr_halted, thr_mwait} !== {exp_state_flags(2), exp_state_flags(1)}) begin
        err++; $display("FAIL rnd_flags[%0d]: got %b want %b", i, {thr_halted, thr_mwait}, {exp_state_flags(2), exp_state_flags(1)}); end
      chk++; if (dut_tags() !== exp_tags()) begin
        err++; $display("FAIL rnd_tags[%0d]: got %h want %h", i, dut_tags(), exp_tags()); end
      tick();
    end
    clr_pulses();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_alternate();
    test_memwait();
    test_halt_resume();
    test_enable_freeze();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
